// File: rtl/ground_pkg.sv
// Shared types and constants for the ground-tile touch controller.
//   tile_state_t    : per-tile confirmation FSM state
//   coord_t         : pixel coordinate widened by one bit so upper bounds never overflow
//   N_TILES         : number of ground tiles fed by the controller
//   GROUND_FRAME_AT : ipcnt value the display stages compare against for frame advance
//   PIX_W           : pixel coordinate width
//   in_span()       : unsigned inclusive range test pos in [lo, lo+len-1]
package ground_pkg;

    localparam int unsigned N_TILES         = 3;
    localparam int unsigned GROUND_FRAME_AT = 6000000;
    localparam int unsigned PIX_W           = 10;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMING  = 2'd1,
        TOUCHED = 2'd2
    } tile_state_t;

    typedef logic [PIX_W:0] coord_t;

    function automatic logic in_span(input logic [PIX_W-1:0] pos,
                                     input coord_t          lo,
                                     input coord_t          len);
        coord_t pos_w;
        coord_t hi;
        pos_w = {1'b0, pos};
        hi    = lo + len - coord_t'(1);
        return (pos_w >= lo) && (pos_w <= hi);
    endfunction

endpackage

// File: rtl/ground_touch_ctrl_if.sv
// Player-position / touch-status bundle between the player logic and the controller.
//   clr         : synchronous level restart
//   px, py      : player feet position in pixels
//   on_ground   : player is standing
//   ipcnt       : free-running animation counter
//   bk_touched  : sticky per-tile touched flags
//   touch_pulse : one-cycle pulse on each bk_touched rise
//   all_touched : registered AND of bk_touched
// master drives the player side, slave is the controller.
interface ground_touch_ctrl_if;
    import ground_pkg::*;

    logic               clr;
    logic [PIX_W-1:0]   px;
    logic [PIX_W-1:0]   py;
    logic               on_ground;
    logic [31:0]        ipcnt;
    logic [N_TILES-1:0] bk_touched;
    logic [N_TILES-1:0] touch_pulse;
    logic               all_touched;

    modport master (
        output clr, px, py, on_ground,
        input  ipcnt, bk_touched, touch_pulse, all_touched
    );

    modport slave (
        input  clr, px, py, on_ground,
        output ipcnt, bk_touched, touch_pulse, all_touched
    );

endinterface

// File: rtl/ground_tile_fsm.sv
// Per-tile touch confirmation: latches once the registered hit has been seen on
// CONFIRM_CYC consecutive cycles, then stays latched until clr or reset.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear, wins over a completing confirm
//   hit        : registered hit for this tile
//   touched    : tile is latched (state == TOUCHED)
//   pulse      : high for the single cycle touched first reads 1
module ground_tile_fsm
    import ground_pkg::*;
#(
    parameter int unsigned CONFIRM_CYC = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic hit,
    output logic touched,
    output logic pulse
);

    localparam logic [7:0] LAST_CNT = 8'(CONFIRM_CYC - 1);

    tile_state_t state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        pulse_q, pulse_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pulse_d = 1'b0;
        if (clr) begin
            state_d = IDLE;
            cnt_d   = 8'd0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (hit) begin
                        if (CONFIRM_CYC == 1) begin
                            state_d = TOUCHED;
                            pulse_d = 1'b1;
                        end else begin
                            state_d = ARMING;
                            cnt_d   = 8'd1;
                        end
                    end
                end
                ARMING: begin
                    if (!hit) begin
                        // Any dropout restarts the run from scratch.
                        state_d = IDLE;
                        cnt_d   = 8'd0;
                    end else if (cnt_q == LAST_CNT) begin
                        state_d = TOUCHED;
                        cnt_d   = 8'd0;
                        pulse_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                TOUCHED: begin
                    state_d = TOUCHED;
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = 8'd0;
                end
            endcase
        end
    end

    assign touched = (state_q == TOUCHED);
    assign pulse   = pulse_q;

endmodule

// File: rtl/ground_touch_ctrl.sv
// Upstream feeder for the ground-tile display stages: free-running animation counter
// plus sticky per-tile touched flags derived from feet position and on-ground status.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of ground_touch_ctrl_if (clr, px, py, on_ground in;
//                ipcnt, bk_touched, touch_pulse, all_touched out)
module ground_touch_ctrl
    import ground_pkg::*;
#(
    parameter int unsigned IPCNT_MAX   = 9999999,
    parameter int unsigned CONFIRM_CYC = 4,
    parameter int unsigned TILE_W      = 64,
    parameter int unsigned TILE_H      = 16,
    parameter int unsigned T0_X        = 64,
    parameter int unsigned T0_Y        = 400,
    parameter int unsigned T1_X        = 256,
    parameter int unsigned T1_Y        = 400,
    parameter int unsigned T2_X        = 448,
    parameter int unsigned T2_Y        = 400
) (
    input  logic                clk,
    input  logic                rst_n,
    ground_touch_ctrl_if.slave  bus
);

    localparam coord_t TW = coord_t'(TILE_W);
    localparam coord_t TH = coord_t'(TILE_H);
    localparam coord_t TILE_X [N_TILES] = '{coord_t'(T0_X), coord_t'(T1_X), coord_t'(T2_X)};
    localparam coord_t TILE_Y [N_TILES] = '{coord_t'(T0_Y), coord_t'(T1_Y), coord_t'(T2_Y)};

    logic [31:0]        ipcnt_q, ipcnt_d;
    logic [N_TILES-1:0] hit_q, hit_d;
    logic [N_TILES-1:0] touched;
    logic [N_TILES-1:0] pulse;
    logic               all_q, all_d;

    // Counter ignores clr: the display animation keeps running across level restarts.
    always_comb begin
        ipcnt_d = (ipcnt_q == IPCNT_MAX) ? 32'd0 : ipcnt_q + 32'd1;
    end

    always_comb begin
        hit_d = '0;
        for (int i = 0; i < N_TILES; i++) begin
            hit_d[i] = bus.on_ground
                     && in_span(bus.px, TILE_X[i], TW)
                     && in_span(bus.py, TILE_Y[i], TH);
        end
    end

    always_comb begin
        all_d = bus.clr ? 1'b0 : &touched;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ipcnt_q <= 32'd0;
            hit_q   <= '0;
            all_q   <= 1'b0;
        end else begin
            ipcnt_q <= ipcnt_d;
            hit_q   <= bus.clr ? '0 : hit_d;
            all_q   <= all_d;
        end
    end

    for (genvar g = 0; g < N_TILES; g++) begin : g_tile
        ground_tile_fsm #(
            .CONFIRM_CYC (CONFIRM_CYC)
        ) u_fsm (
            .clk     (clk),
            .rst_n   (rst_n),
            .clr     (bus.clr),
            .hit     (hit_q[g]),
            .touched (touched[g]),
            .pulse   (pulse[g])
        );
    end

    assign bus.ipcnt       = ipcnt_q;
    assign bus.bk_touched  = touched;
    assign bus.touch_pulse = pulse;
    assign bus.all_touched = all_q;

endmodule

// File: tb/tb_ground_touch_ctrl.sv
// Self-checking bench for ground_touch_ctrl: directed scenarios with explicit expected
// values, then randomized stimulus against a run-length reference model.
module tb_ground_touch_ctrl;
    import ground_pkg::*;

    logic clk;
    logic rst_n;
    logic       s_clr;
    logic [9:0] s_px;
    logic [9:0] s_py;
    logic       s_og;

    int n_checks = 0;
    int n_fail   = 0;

    ground_touch_ctrl_if gif0 ();
    ground_touch_ctrl_if gif1 ();

    assign gif0.clr = s_clr;
    assign gif0.px = s_px;
    assign gif0.py = s_py;
    assign gif0.on_ground = s_og;
    assign gif1.clr = s_clr;
    assign gif1.px = s_px;
    assign gif1.py = s_py;
    assign gif1.on_ground = s_og;

    ground_touch_ctrl #(
        .IPCNT_MAX   (9),
        .CONFIRM_CYC (4)
    ) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (gif0.slave)
    );

    ground_touch_ctrl #(
        .CONFIRM_CYC (1)
    ) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (gif1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int tile_x [3] = '{64, 256, 448};
    int tile_y [3] = '{400, 400, 400};
    int cyc    [2] = '{4, 1};

    logic [31:0] m_ipcnt;
    logic [2:0]  m_hit;
    logic [2:0]  m_touched [2];
    logic [2:0]  m_pulse [2];
    logic        m_all [2];
    int          m_run [2][3];

    function automatic logic qual(input int t);
        int x;
        int y;
        x = int'(s_px);
        y = int'(s_py);
        return s_og && x >= tile_x[t] && x <= tile_x[t] + 63 && y >= tile_y[t] && y <= tile_y[t] + 15;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ipcnt <= 0;
            m_hit   <= '0;
            for (int d = 0; d < 2; d++) begin
                m_touched[d] <= '0;
                m_pulse[d]   <= '0;
                m_all[d]     <= 1'b0;
                for (int t = 0; t < 3; t++) m_run[d][t] <= 0;
            end
        end else begin
            m_ipcnt <= (m_ipcnt == 32'd9) ? 32'd0 : m_ipcnt + 32'd1;
            for (int d = 0; d < 2; d++) begin
                m_all[d] <= s_clr ? 1'b0 : &m_touched[d];
                for (int t = 0; t < 3; t++) begin
                    m_pulse[d][t] <= 1'b0;
                    if (s_clr) begin
                        m_touched[d][t] <= 1'b0;
                        m_run[d][t]     <= 0;
                    end else if (!m_touched[d][t]) begin
                        if (m_hit[t]) begin
                            if (m_run[d][t] + 1 >= cyc[d]) begin
                                m_touched[d][t] <= 1'b1;
                                m_pulse[d][t]   <= 1'b1;
                            end else begin
                                m_run[d][t] <= m_run[d][t] + 1;
                            end
                        end else begin
                            m_run[d][t] <= 0;
                        end
                    end
                end
            end
            for (int t = 0; t < 3; t++) m_hit[t] <= s_clr ? 1'b0 : qual(t);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_in(input int px, input int py, input logic og, input logic clr);
        s_px  = 10'(px);
        s_py  = 10'(py);
        s_og  = og;
        s_clr = clr;
    endtask

    task automatic do_clear();
        set_in(0, 0, 1'b0, 1'b1);
        tick();
        s_clr = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        #3;
        n_checks++;
        if (gif0.ipcnt !== 32'd0 || gif0.bk_touched !== 3'b000 || gif0.touch_pulse !== 3'b000
            || gif0.all_touched !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_dut0 got ipcnt=%0d bk=%b pulse=%b all=%b want all zero",
                     gif0.ipcnt, gif0.bk_touched, gif0.touch_pulse, gif0.all_touched);
        end
        n_checks++;
        if (gif1.ipcnt !== 32'd0 || gif1.bk_touched !== 3'b000 || gif1.touch_pulse !== 3'b000
            || gif1.all_touched !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_dut1 got ipcnt=%0d bk=%b pulse=%b all=%b want all zero",
                     gif1.ipcnt, gif1.bk_touched, gif1.touch_pulse, gif1.all_touched);
        end
    endtask

    task automatic test_ipcnt();
        int exp;
        @(negedge clk);
        rst_n = 1'b1;
        exp = 0;
        n_checks++;
        if (gif0.ipcnt !== 32'(exp)) begin
            n_fail++;
            $display("FAIL ipcnt_start got=%0d want=%0d", gif0.ipcnt, exp);
        end
        for (int n = 1; n <= 25; n++) begin
            s_clr = (n >= 12 && n <= 14);
            tick();
            exp = (exp == 9) ? 0 : exp + 1;
            n_checks++;
            if (gif0.ipcnt !== 32'(exp)) begin
                n_fail++;
                $display("FAIL ipcnt_seq n=%0d got=%0d want=%0d", n, gif0.ipcnt, exp);
            end
        end
        s_clr = 1'b0;
    endtask

    task automatic test_single_tile();
        do_clear();
        set_in(80, 405, 1'b1, 1'b0);
        for (int e = 0; e <= 6; e++) begin
            tick();
            n_checks++;
            if (gif0.bk_touched !== ((e >= 4) ? 3'b001 : 3'b000)
                || gif0.touch_pulse !== ((e == 4) ? 3'b001 : 3'b000)) begin
                n_fail++;
                $display("FAIL single_dut0 e=%0d got bk=%b pulse=%b want bk=%b pulse=%b", e,
                         gif0.bk_touched, gif0.touch_pulse,
                         (e >= 4) ? 3'b001 : 3'b000, (e == 4) ? 3'b001 : 3'b000);
            end
            n_checks++;
            if (gif1.bk_touched !== ((e >= 1) ? 3'b001 : 3'b000)
                || gif1.touch_pulse !== ((e == 1) ? 3'b001 : 3'b000)) begin
                n_fail++;
                $display("FAIL single_dut1 e=%0d got bk=%b pulse=%b want bk=%b pulse=%b", e,
                         gif1.bk_touched, gif1.touch_pulse,
                         (e >= 1) ? 3'b001 : 3'b000, (e == 1) ? 3'b001 : 3'b000);
            end
        end
    endtask

    task automatic test_glitch_and_edges();
        logic [8:0] og_seq;
        og_seq = 9'b1_1111_0111;  // bit e applied before edge e: 1,1,1,0,1,1,1,1,1
        do_clear();
        for (int e = 0; e <= 8; e++) begin
            set_in(80, 405, og_seq[e], 1'b0);
            tick();
            n_checks++;
            if (gif0.bk_touched[0] !== (e >= 8)) begin
                n_fail++;
                $display("FAIL glitch e=%0d got=%b want=%b", e, gif0.bk_touched[0], e >= 8);
            end
        end
        do_clear();
        set_in(128, 405, 1'b1, 1'b0);
        for (int e = 0; e <= 5; e++) begin
            tick();
            n_checks++;
            if (gif0.bk_touched !== 3'b000) begin
                n_fail++;
                $display("FAIL px128_miss e=%0d got=%b want=000", e, gif0.bk_touched);
            end
        end
        do_clear();
        set_in(127, 405, 1'b1, 1'b0);
        for (int e = 0; e <= 4; e++) begin
            tick();
            n_checks++;
            if (gif0.bk_touched !== ((e >= 4) ? 3'b001 : 3'b000)) begin
                n_fail++;
                $display("FAIL px127_hit e=%0d got=%b want=%b", e, gif0.bk_touched,
                         (e >= 4) ? 3'b001 : 3'b000);
            end
        end
    endtask

    task automatic test_walk();
        int xs [3] = '{80, 300, 500};
        logic [2:0] want_bk;
        do_clear();
        for (int t = 0; t < 3; t++) begin
            set_in(xs[t], 400, 1'b1, 1'b0);
            for (int e = 0; e <= 4; e++) tick();
            want_bk = 3'((1 << (t + 1)) - 1);
            n_checks++;
            if (gif0.bk_touched !== want_bk || gif0.all_touched !== 1'b0) begin
                n_fail++;
                $display("FAIL walk_tile%0d got bk=%b all=%b want bk=%b all=0", t,
                         gif0.bk_touched, gif0.all_touched, want_bk);
            end
        end
        set_in(0, 0, 1'b1, 1'b0);
        for (int e = 0; e < 3; e++) begin
            tick();
            n_checks++;
            if (gif0.bk_touched !== 3'b111 || gif0.all_touched !== 1'b1) begin
                n_fail++;
                $display("FAIL walk_after e=%0d got bk=%b all=%b want bk=111 all=1", e,
                         gif0.bk_touched, gif0.all_touched);
            end
        end
    endtask

    task automatic test_clr_priority();
        do_clear();
        set_in(80, 405, 1'b1, 1'b0);
        for (int e = 0; e <= 3; e++) tick();
        s_clr = 1'b1;
        tick();
        n_checks++;
        if (gif0.bk_touched !== 3'b000 || gif0.touch_pulse !== 3'b000) begin
            n_fail++;
            $display("FAIL clr_complete got bk=%b pulse=%b want 000/000",
                     gif0.bk_touched, gif0.touch_pulse);
        end
        s_clr = 1'b0;
        for (int e = 0; e <= 4; e++) begin
            tick();
            n_checks++;
            if (gif0.bk_touched !== ((e >= 4) ? 3'b001 : 3'b000)
                || gif0.touch_pulse !== ((e == 4) ? 3'b001 : 3'b000)) begin
                n_fail++;
                $display("FAIL clr_restand e=%0d got bk=%b pulse=%b", e,
                         gif0.bk_touched, gif0.touch_pulse);
            end
        end
        s_clr = 1'b1;
        for (int e = 0; e < 3; e++) begin
            tick();
            n_checks++;
            if (gif0.bk_touched !== 3'b000 || gif0.touch_pulse !== 3'b000
                || gif0.all_touched !== 1'b0 || gif1.bk_touched !== 3'b000) begin
                n_fail++;
                $display("FAIL clr_held e=%0d got bk0=%b pulse0=%b all0=%b bk1=%b want zeros", e,
                         gif0.bk_touched, gif0.touch_pulse, gif0.all_touched, gif1.bk_touched);
            end
        end
        s_clr = 1'b0;
    endtask

    task automatic test_async_reset();
        do_clear();
        set_in(80, 405, 1'b1, 1'b0);
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (gif0.bk_touched !== 3'b000 || gif0.touch_pulse !== 3'b000 || gif0.ipcnt !== 32'd0
            || gif1.bk_touched !== 3'b000) begin
            n_fail++;
            $display("FAIL rst_arming got bk0=%b pulse0=%b ipcnt=%0d bk1=%b want zeros",
                     gif0.bk_touched, gif0.touch_pulse, gif0.ipcnt, gif1.bk_touched);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int e = 0; e <= 4; e++) begin
            tick();
            n_checks++;
            if (gif0.bk_touched !== ((e >= 4) ? 3'b001 : 3'b000)
                || gif0.touch_pulse !== ((e == 4) ? 3'b001 : 3'b000)) begin
                n_fail++;
                $display("FAIL rst_restand e=%0d got bk=%b pulse=%b", e,
                         gif0.bk_touched, gif0.touch_pulse);
            end
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (gif0.bk_touched !== 3'b000 || gif0.all_touched !== 1'b0
            || gif1.bk_touched !== 3'b000 || gif1.touch_pulse !== 3'b000) begin
            n_fail++;
            $display("FAIL rst_touched got bk0=%b all0=%b bk1=%b pulse1=%b want zeros",
                     gif0.bk_touched, gif0.all_touched, gif1.bk_touched, gif1.touch_pulse);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        int px_opt [6] = '{80, 127, 128, 300, 500, 0};
        int py_opt [6] = '{400, 405, 415, 416, 399, 0};
        int px;
        int py;
        int hold;
        do_clear();
        for (int it = 0; it < 300; it++) begin
            px = px_opt[$urandom_range(0, 5)];
            if (px == 0) px = int'($urandom_range(0, 1023));
            py = py_opt[$urandom_range(0, 5)];
            if (py == 0) py = int'($urandom_range(0, 1023));
            set_in(px, py, $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
            hold = int'($urandom_range(1, 5));
            for (int h = 0; h < hold; h++) begin
                tick();
                n_checks++;
                if (gif0.bk_touched !== m_touched[0] || gif0.touch_pulse !== m_pulse[0]
                    || gif0.all_touched !== m_all[0] || gif0.ipcnt !== m_ipcnt) begin
                    n_fail++;
                    $display("FAIL rand_dut0 it=%0d got bk=%b p=%b a=%b c=%0d want bk=%b p=%b a=%b c=%0d",
                             it, gif0.bk_touched, gif0.touch_pulse, gif0.all_touched, gif0.ipcnt,
                             m_touched[0], m_pulse[0], m_all[0], m_ipcnt);
                end
                n_checks++;
                if (gif1.bk_touched !== m_touched[1] || gif1.touch_pulse !== m_pulse[1]
                    || gif1.all_touched !== m_all[1]) begin
                    n_fail++;
                    $display("FAIL rand_dut1 it=%0d got bk=%b p=%b a=%b want bk=%b p=%b a=%b",
                             it, gif1.bk_touched, gif1.touch_pulse, gif1.all_touched,
                             m_touched[1], m_pulse[1], m_all[1]);
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        set_in(0, 0, 1'b0, 1'b0);
        test_reset();
        test_ipcnt();
        test_single_tile();
        test_glitch_and_edges();
        test_walk();
        test_clr_priority();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
